pipe_flow_ctrl: RTL and testbench
=================================

// Module: pipe_flow_ctrl
// PURPOSE
//  Parametrised N-stage pipeline flow controller; generalises the fixed 5-stage RDY/BUSY hazard unit.
//  Tracks per-stage occupancy and advances stages with a ready chain.
//  Applies flush from any stage, not only one fixed stage, and counts per-stage stall cycles.
//  Sits between the datapath stages and all pipeline registers, PC load and the imem/dmem request gates.
// PARAMETERS
//  NUM_STAGES   5    number of stages; stage 0 = fetch, stage NUM_STAGES-1 = writeback/retire
//  CNT_W        16   width of each saturating stall counter
// PORTS
//  clk           in   1              clock
//  rst           in   1              asynchronous, active-high reset
//  fetch_en_i    in   1              allow stage 0 to start fetches
//  done_i        in   NUM_STAGES     stage s work finished this cycle (mem resp, or 1 if no mem op)
//  hold_i        in   NUM_STAGES     stage s hazard stall (e.g. operand not ready)
//  flush_i       in   NUM_STAGES     stage s requests kill of all younger stages (mispredict)
//  cnt_clr_i     in   1              synchronous clear of all stall counters
//  valid_o       out  NUM_STAGES     stage s occupied
//  load_o        out  NUM_STAGES     load pipeline reg after stage s (s<N-1); load_o[0] also loads PC
//  kill_o        out  NUM_STAGES     1-cycle pulse: stage s content discarded; in-flight resp must be dropped
//  redirect_o    out  1              flush taken this cycle; PC loads the redirect target
//  retire_o      out  1              instruction leaves the last stage
//  stall_cnt_o   out  NUM_STAGES*CNT_W  per-stage stall cycles, stage s at [s*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset (async): valid_q=0; load_o, kill_o, redirect_o, retire_o =0; counters=0.
//  adv[s] = valid_q[s] & done_i[s] & ~hold_i[s] & (s==N-1 | ~valid_q[s+1] | adv[s+1]).
//   Purely combinational, evaluated oldest stage first; no combinational path from load_o back to done_i.
//  load_o[s] = adv[s]; retire_o = adv[N-1].
//  Next state, no flush:
//   valid_q[s] <= adv[s-1] | (valid_q[s] & ~adv[s]) for s>0.
//   valid_q[0] <= fetch_en_i & (adv[0] | ~valid_q[0] | valid_q[0]).
//   Net effect: stage 0 refetches the cycle after it advances; it stays idle while fetch_en_i=0.
//  Flush: honored only when the requesting stage k also has adv[k]=1.
//   Otherwise it is ignored and the requester keeps it asserted.
//   If several are eligible, the highest k (oldest) wins.
//   On taken flush at k: redirect_o=1 and kill_o[j]=valid_q[j] for j<k.
//   Next cycle: valid_q[1..k]=0, because the wrong-path instruction from k-1 must not enter k.
//   valid_q[k+1] <= 1 (k's own instruction proceeds); valid_q[0] <= fetch_en_i (restart at new PC).
//   load_o[j] for j<k is forced 0; load_o[k]=1.
//  Simultaneous flush and retire are independent. A flush at N-1 kills all younger stages.
//  Stall count: cnt[s] increments when valid_q[s] & ~adv[s]; it saturates at 2^CNT_W-1 (no wrap).
//   cnt_clr_i wins over increment.
//  Reset mid-operation: all state clears immediately. No retire or kill pulses are emitted.
//  Latency: a stage with done=1 and hold=0 advances every cycle.
//   An empty N-stage pipe retires the first instruction N cycles after fetch_en_i.
//  Bubbles: an empty stage never asserts load_o.
//   Downstream valid is cleared by the ~adv term, not by loading a valid=0 entry.
// STRUCTURE
//  Package pipe_ctrl_pkg holds:
//   NUM_STAGES_DEFAULT and the stage index constants ST_IF=0, ST_ID, ST_EX, ST_MEM, ST_WB.
//   typedef stage_vec_t = logic [NUM_STAGES-1:0].
//   flush_sel() function: priority pick of the highest eligible index.
//  Sub-module sat_counter #(CNT_W), one instance per stage through a generate loop.
//  The rest lives in one module: adv chain, flush select, valid_q array.
// TESTING
//  1 Reset, then fetch_en_i=1 with all done_i=1, hold_i=0
//    -> valid_o fills one stage per cycle; retire_o first high on cycle 5, then every cycle.
//  2 Full pipe, hold_i[2]=1 for 3 cycles
//    -> load_o[0..2]=0 and stages 0-2 frozen; stage 3 drains to a bubble; stall_cnt[2]=3.
//  3 Full pipe, flush_i[2]=1 with adv[2]=1
//    -> redirect_o=1, kill_o=5'b00011; next cycle valid_o=5'b11001 (stage 0 refetching).
//  4 flush_i[2]=1 while done_i[2]=0 -> no redirect or kill.
//    Raise done_i[2] 2 cycles later -> flush taken that cycle.
//  5 flush_i[3] and flush_i[1] both eligible -> stage 3 wins; kill_o=5'b00111.
//  6 Counter saturation: CNT_W=4, stall 20 cycles -> cnt=15.
//    cnt_clr_i -> 0. Async rst mid-stall -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, types and the flush priority picker for the pipeline flow controller.
package pipe_ctrl_pkg;

    localparam int NUM_STAGES_DEFAULT = 5;

    localparam int ST_IF  = 0;
    localparam int ST_ID  = 1;
    localparam int ST_EX  = 2;
    localparam int ST_MEM = 3;
    localparam int ST_WB  = 4;

    // The picker works on a fixed-width vector; pipelines are zero-extended into it.
    localparam int MAX_STAGES  = 32;
    localparam int STAGE_IDX_W = 5;

    typedef logic [NUM_STAGES_DEFAULT-1:0] stage_vec_t;

    typedef struct packed {
        logic                   hit;
        logic [STAGE_IDX_W-1:0] idx;
    } flush_pick_t;

    // Highest set index wins: the oldest requesting stage owns the redirect.
    function automatic flush_pick_t flush_sel(input logic [MAX_STAGES-1:0] elig);
        flush_pick_t res;
        res = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (elig[i]) begin
                res.hit = 1'b1;
                res.idx = STAGE_IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// N-stage pipeline flow controller: ready-chain advance, oldest-wins flush and
// per-stage saturating stall counters.
module pipe_flow_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_en_i,
    input  logic [NUM_STAGES-1:0]       done_i,
    input  logic [NUM_STAGES-1:0]       hold_i,
    input  logic [NUM_STAGES-1:0]       flush_i,
    input  logic                        cnt_clr_i,
    output logic [NUM_STAGES-1:0]       valid_o,
    output logic [NUM_STAGES-1:0]       load_o,
    output logic [NUM_STAGES-1:0]       kill_o,
    output logic                        redirect_o,
    output logic                        retire_o,
    output logic [NUM_STAGES*CNT_W-1:0] stall_cnt_o
);

    logic [NUM_STAGES-1:0] r_valid;
    logic [NUM_STAGES-1:0] w_adv;
    logic [NUM_STAGES-1:0] w_valid_d;
    logic [NUM_STAGES-1:0] w_load;
    logic [NUM_STAGES-1:0] w_kill;
    logic [NUM_STAGES-1:0] w_stall;
    logic [MAX_STAGES-1:0] w_elig;
    flush_pick_t           w_pick;

    // Ready chain, oldest stage first: a stage may move when the next one is empty or moving.
    always_comb begin
        logic w_free;
        w_adv  = '0;
        w_free = 1'b1;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            w_adv[s] = r_valid[s] & done_i[s] & ~hold_i[s] & w_free;
            w_free   = ~r_valid[s] | w_adv[s];
        end
    end

    // A flush only counts when its stage is actually advancing this cycle.
    always_comb begin
        w_elig                   = '0;
        w_elig[NUM_STAGES-1:0]   = flush_i & w_adv;
    end

    assign w_pick = flush_sel(w_elig);

    always_comb begin
        w_kill = '0;
        w_load = w_adv;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (w_pick.hit && (STAGE_IDX_W'(s) < w_pick.idx)) begin
                w_kill[s] = r_valid[s];
                w_load[s] = 1'b0;
            end
        end
    end

    // Stage 0 always restarts when fetch is enabled; wrong-path stages 1..k are emptied on flush.
    always_comb begin
        w_valid_d        = '0;
        w_valid_d[ST_IF] = fetch_en_i;
        for (int s = 1; s < NUM_STAGES; s++) begin
            w_valid_d[s] = w_adv[s-1] | (r_valid[s] & ~w_adv[s]);
            if (w_pick.hit) begin
                if (STAGE_IDX_W'(s) <= w_pick.idx) begin
                    w_valid_d[s] = 1'b0;
                end else if (STAGE_IDX_W'(s) == w_pick.idx + STAGE_IDX_W'(1)) begin
                    w_valid_d[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_d;
        end
    end

    assign w_stall = r_valid & ~w_adv;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stall_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .i_clr (cnt_clr_i),
            .i_inc (w_stall[g]),
            .o_cnt (stall_cnt_o[g*CNT_W +: CNT_W])
        );
    end

    assign valid_o    = r_valid;
    assign load_o     = w_load;
    assign kill_o     = w_kill;
    assign redirect_o = w_pick.hit;
    assign retire_o   = w_adv[NUM_STAGES-1];

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: fill, hold, flush timing/priority, counter saturation, async reset.
module tb_pipe_flow_ctrl;

    localparam int N  = 5;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_en;
    logic [N-1:0]    done;
    logic [N-1:0]    hold;
    logic [N-1:0]    flush;
    logic            cnt_clr;
    logic [N-1:0]    valid;
    logic [N-1:0]    load;
    logic [N-1:0]    kill;
    logic            redirect;
    logic            retire;
    logic [N*CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_flow_ctrl #(
        .NUM_STAGES (N),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en_i  (fetch_en),
        .done_i      (done),
        .hold_i      (hold),
        .flush_i     (flush),
        .cnt_clr_i   (cnt_clr),
        .valid_o     (valid),
        .load_o      (load),
        .kill_o      (kill),
        .redirect_o  (redirect),
        .retire_o    (retire),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pipe();
        hold     = '0;
        flush    = '0;
        done     = '1;
        fetch_en = 1'b1;
        cnt_clr  = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b0; done = '0; hold = '0; flush = '0; cnt_clr = 1'b0;
        step();
        n_checks++;
        if ({valid, load, kill, redirect, retire} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b load=%b kill=%b redir=%b ret=%b, expected all 0", valid, load, kill, redirect, retire);
        end
        n_checks++;
        if (stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h expected 0", stall_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill();
        logic [N-1:0] fill_tab [5] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
        done = '1; fetch_en = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            n_checks++;
            if (valid !== fill_tab[n]) begin
                n_fail++;
                $display("FAIL fill_valid[%0d]: got %b expected %b", n + 1, valid, fill_tab[n]);
            end
            n_checks++;
            if (retire !== (n == 4)) begin
                n_fail++;
                $display("FAIL fill_retire[%0d]: got %b expected %b", n + 1, retire, (n == 4));
            end
        end
        step();
        n_checks++;
        if (retire !== 1'b1 || valid !== 5'b11111) begin
            n_fail++;
            $display("FAIL fill_steady: retire=%b valid=%b expected 1 11111", retire, valid);
        end
    endtask

    task automatic test_hold();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        hold = 5'b00100;
        #1;
        n_checks++;
        if (load !== 5'b11000) begin
            n_fail++;
            $display("FAIL hold_load1: got %b expected 11000", load);
        end
        step();
        n_checks++;
        if (load !== 5'b10000 || valid !== 5'b10111) begin
            n_fail++;
            $display("FAIL hold_cyc2: load=%b valid=%b expected 10000 10111", load, valid);
        end
        step();
        n_checks++;
        if (load !== 5'b00000 || valid !== 5'b00111) begin
            n_fail++;
            $display("FAIL hold_cyc3: load=%b valid=%b expected 00000 00111", load, valid);
        end
        step();
        n_checks++;
        if (stall_cnt[2*CW +: CW] !== 4'd3 || stall_cnt[3*CW +: CW] !== 4'd0) begin
            n_fail++;
            $display("FAIL hold_cnt: cnt2=%0d cnt3=%0d expected 3 0", stall_cnt[2*CW +: CW], stall_cnt[3*CW +: CW]);
        end
        n_checks++;
        if (valid !== 5'b00111) begin
            n_fail++;
            $display("FAIL hold_frozen: got %b expected 00111", valid);
        end
        hold = '0;
    endtask

    task automatic test_flush();
        fill_pipe();
        flush = 5'b00100;
        #1;
        n_checks++;
        if (redirect !== 1'b1 || kill !== 5'b00011) begin
            n_fail++;
            $display("FAIL flush_kill: redirect=%b kill=%b expected 1 00011", redirect, kill);
        end
        n_checks++;
        if (load !== 5'b11100) begin
            n_fail++;
            $display("FAIL flush_load: got %b expected 11100", load);
        end
        step();
        flush = '0;
        #1;
        n_checks++;
        if (valid !== 5'b11001 || redirect !== 1'b0 || kill !== 5'b00000) begin
            n_fail++;
            $display("FAIL flush_next: valid=%b redirect=%b kill=%b expected 11001 0 00000", valid, redirect, kill);
        end
    endtask

    task automatic test_flush_wait();
        fill_pipe();
        done  = 5'b11011;
        flush = 5'b00100;
        #1;
        n_checks++;
        if (redirect !== 1'b0 || kill !== 5'b00000) begin
            n_fail++;
            $display("FAIL wait_c1: redirect=%b kill=%b expected 0 00000", redirect, kill);
        end
        step();
        n_checks++;
        if (redirect !== 1'b0 || kill !== 5'b00000 || valid !== 5'b10111) begin
            n_fail++;
            $display("FAIL wait_c2: redirect=%b kill=%b valid=%b expected 0 00000 10111", redirect, kill, valid);
        end
        step();
        done = '1;
        #1;
        n_checks++;
        if (redirect !== 1'b1 || kill !== 5'b00011) begin
            n_fail++;
            $display("FAIL wait_taken: redirect=%b kill=%b expected 1 00011", redirect, kill);
        end
        step();
        flush = '0;
        #1;
        n_checks++;
        if (valid !== 5'b01001) begin
            n_fail++;
            $display("FAIL wait_next: got %b expected 01001", valid);
        end
    endtask

    task automatic test_flush_priority();
        fill_pipe();
        flush = 5'b01010;
        #1;
        n_checks++;
        if (redirect !== 1'b1 || kill !== 5'b00111 || load !== 5'b11000) begin
            n_fail++;
            $display("FAIL prio_pick: redirect=%b kill=%b load=%b expected 1 00111 11000", redirect, kill, load);
        end
        step();
        flush = '0;
        #1;
        n_checks++;
        if (valid !== 5'b10001) begin
            n_fail++;
            $display("FAIL prio_next: got %b expected 10001", valid);
        end
        fill_pipe();
        flush = 5'b10000;
        #1;
        n_checks++;
        if (kill !== 5'b01111 || load !== 5'b10000 || retire !== 1'b1 || redirect !== 1'b1) begin
            n_fail++;
            $display("FAIL last_flush: kill=%b load=%b retire=%b redirect=%b expected 01111 10000 1 1", kill, load, retire, redirect);
        end
        step();
        flush = '0;
        #1;
        n_checks++;
        if (valid !== 5'b00001) begin
            n_fail++;
            $display("FAIL last_flush_next: got %b expected 00001", valid);
        end
    endtask

    task automatic test_saturation();
        fill_pipe();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        hold = 5'b00100;
        repeat (20) step();
        n_checks++;
        if (stall_cnt[2*CW +: CW] !== 4'd15 || stall_cnt[0 +: CW] !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_cnt: cnt2=%0d cnt0=%0d expected 15 15", stall_cnt[2*CW +: CW], stall_cnt[0 +: CW]);
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_checks++;
        if (stall_cnt[2*CW +: CW] !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_clr: got %0d expected 0", stall_cnt[2*CW +: CW]);
        end
        step();
        n_checks++;
        if (stall_cnt[2*CW +: CW] !== 4'd1) begin
            n_fail++;
            $display("FAIL sat_restart: got %0d expected 1", stall_cnt[2*CW +: CW]);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({valid, load, kill, redirect, retire} !== '0 || stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_rst: valid=%b load=%b kill=%b redir=%b ret=%b cnt=%h expected all 0", valid, load, kill, redirect, retire, stall_cnt);
        end
        hold = '0;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hold();
        test_flush();
        test_flush_wait();
        test_flush_priority();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
